// File: rtl/rgb_pwm_if.sv
// Duty words in, LED drives and period strobe out, for the RGB PWM stage.
interface rgb_pwm_if #(
    parameter int DUTY_W = 7
);
    logic              en;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] g_duty;
    logic [DUTY_W-1:0] b_duty;
    logic              led_r;
    logic              led_g;
    logic              led_b;
    logic              period_start;

    modport master (
        output en, r_duty, g_duty, b_duty,
        input  led_r, led_g, led_b, period_start
    );

    modport slave (
        input  en, r_duty, g_duty, b_duty,
        output led_r, led_g, led_b, period_start
    );
endinterface

// File: rtl/rgb_pwm.sv
// Three-channel PWM LED driver with prescaler and period-aligned duty shadows; led_* lag pwm_cnt by 1 clk, no backpressure.
// Define RGB_PWM_FADE_EN to make shadows step by one toward the duty inputs at each period wrap.
module rgb_pwm #(
    parameter int DUTY_W   = 7,
    parameter int PRESCALE = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    rgb_pwm_if.slave   bus
);
    localparam int                PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] CNT_MAX = DUTY_W'((1 << DUTY_W) - 2);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            r_state;
    logic [PRE_W-1:0]  r_pre_cnt;
    logic [DUTY_W-1:0] r_pwm_cnt;
    logic [DUTY_W-1:0] r_shadow_r;
    logic [DUTY_W-1:0] r_shadow_g;
    logic [DUTY_W-1:0] r_shadow_b;
    logic              r_led_r;
    logic              r_led_g;
    logic              r_led_b;
    logic              r_period_start;

    logic w_tick;
    logic w_wrap;

    assign w_tick = (r_pre_cnt == PRE_MAX);
    assign w_wrap = w_tick && (r_pwm_cnt == CNT_MAX);

`ifdef RGB_PWM_FADE_EN
    function automatic logic [DUTY_W-1:0] fade_step(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
        if (cur < tgt)      return cur + 1'b1;
        else if (cur > tgt) return cur - 1'b1;
        else                return cur;
    endfunction
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_pre_cnt      <= '0;
            r_pwm_cnt      <= '0;
            r_shadow_r     <= '0;
            r_shadow_g     <= '0;
            r_shadow_b     <= '0;
            r_led_r        <= 1'b0;
            r_led_g        <= 1'b0;
            r_led_b        <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pre_cnt      <= '0;
                    r_pwm_cnt      <= '0;
                    r_led_r        <= 1'b0;
                    r_led_g        <= 1'b0;
                    r_led_b        <= 1'b0;
                    r_period_start <= 1'b0;
                    // Entry loads the duties directly so the first period is already correct.
                    if (bus.en) begin
                        r_state        <= S_RUN;
                        r_shadow_r     <= bus.r_duty;
                        r_shadow_g     <= bus.g_duty;
                        r_shadow_b     <= bus.b_duty;
                        r_period_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!bus.en) begin
                        r_state        <= S_IDLE;
                        r_pre_cnt      <= '0;
                        r_pwm_cnt      <= '0;
                        r_led_r        <= 1'b0;
                        r_led_g        <= 1'b0;
                        r_led_b        <= 1'b0;
                        r_period_start <= 1'b0;
                    end else begin
                        r_led_r        <= (r_pwm_cnt < r_shadow_r);
                        r_led_g        <= (r_pwm_cnt < r_shadow_g);
                        r_led_b        <= (r_pwm_cnt < r_shadow_b);
                        r_period_start <= w_wrap;
                        if (w_tick) begin
                            r_pre_cnt <= '0;
                            r_pwm_cnt <= w_wrap ? '0 : r_pwm_cnt + 1'b1;
                        end else begin
                            r_pre_cnt <= r_pre_cnt + 1'b1;
                        end
                        if (w_wrap) begin
`ifdef RGB_PWM_FADE_EN
                            r_shadow_r <= fade_step(r_shadow_r, bus.r_duty);
                            r_shadow_g <= fade_step(r_shadow_g, bus.g_duty);
                            r_shadow_b <= fade_step(r_shadow_b, bus.b_duty);
`else
                            r_shadow_r <= bus.r_duty;
                            r_shadow_g <= bus.g_duty;
                            r_shadow_b <= bus.b_duty;
`endif
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.led_r        = r_led_r;
    assign bus.led_g        = r_led_g;
    assign bus.led_b        = r_led_b;
    assign bus.period_start = r_period_start;
endmodule

// File: tb/tb_rgb_pwm.sv
// Bench for rgb_pwm: one instance at PRESCALE=1, one at PRESCALE=4, checked per period against duty arithmetic.
module tb_rgb_pwm;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rgb_pwm_if #(.DUTY_W(7)) if0();
    rgb_pwm_if #(.DUTY_W(7)) if1();

    rgb_pwm #(.DUTY_W(7), .PRESCALE(1)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    rgb_pwm #(.DUTY_W(7), .PRESCALE(4)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic drive(input int which, input logic e, input logic [6:0] r, g, b);
        if (which == 0) begin
            if0.en = e; if0.r_duty = r; if0.g_duty = g; if0.b_duty = b;
        end else begin
            if1.en = e; if1.r_duty = r; if1.g_duty = g; if1.b_duty = b;
        end
    endtask

    task automatic read(input int which, output logic lr, lg, lb, ps);
        if (which == 0) begin
            lr = if0.led_r; lg = if0.led_g; lb = if0.led_b; ps = if0.period_start;
        end else begin
            lr = if1.led_r; lg = if1.led_g; lb = if1.led_b; ps = if1.period_start;
        end
    endtask

    task automatic wait_ps(input int which, input int budget, output bit ok);
        logic lr, lg, lb, ps;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            read(which, lr, lg, lb, ps);
            if (ps === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Leaves the bench at the negedge of the period_start cycle following enable entry.
    task automatic start(input int which, input logic [6:0] r, g, b, output bit ok);
        drive(which, 1'b0, r, g, b);
        repeat (2) @(negedge clk);
        drive(which, 1'b1, r, g, b);
        wait_ps(which, 4, ok);
    endtask

    // Observes one full period: step s covers clk offsets s*p+1 .. s*p+p after the strobe cycle.
    task automatic measure(input int which, input int p, input int dr, dg, db,
                           input int chg_c, input logic [6:0] nr, ng, nb,
                           output int cr, cg, cb, output int shape_err, ps_err);
        logic lr, lg, lb, ps;
        int len;
        len = 127 * p;
        cr = 0; cg = 0; cb = 0; shape_err = 0; ps_err = 0;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            read(which, lr, lg, lb, ps);
            if (lr === 1'b1) cr++;
            if (lg === 1'b1) cg++;
            if (lb === 1'b1) cb++;
            if (lr !== 1'(((c - 1) / p) < dr)) shape_err++;
            if (lg !== 1'(((c - 1) / p) < dg)) shape_err++;
            if (lb !== 1'(((c - 1) / p) < db)) shape_err++;
            if (ps !== 1'(c == len)) ps_err++;
            if (c == chg_c) drive(which, 1'b1, nr, ng, nb);
        end
    endtask

    function automatic int next_shadow(input int cur, input int tgt);
`ifdef RGB_PWM_FADE_EN
        if (cur < tgt) return cur + 1;
        if (cur > tgt) return cur - 1;
        return cur;
`else
        return tgt;
`endif
    endfunction

    task automatic test_reset();
        logic lr, lg, lb, ps;
        bit ok;
        int cr, cg, cb, se, pe;
        #2;
        read(0, lr, lg, lb, ps);
        n_checks++;
        if ({lr, lg, lb, ps} !== 4'b0) $display("FAIL reset_init0 got=%b want=0000", {lr, lg, lb, ps});
        else n_pass++;
        read(1, lr, lg, lb, ps);
        n_checks++;
        if ({lr, lg, lb, ps} !== 4'b0) $display("FAIL reset_init1 got=%b want=0000", {lr, lg, lb, ps});
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        start(0, 7'd127, 7'd127, 7'd127, ok);
        repeat (20) @(negedge clk);
        read(0, lr, lg, lb, ps);
        n_checks++;
        if ({lr, lg, lb} !== 3'b111) $display("FAIL reset_prerun got=%b want=111", {lr, lg, lb});
        else n_pass++;
        #2 reset_n = 1'b0;
        #1 read(0, lr, lg, lb, ps);
        n_checks++;
        if ({lr, lg, lb, ps} !== 4'b0) $display("FAIL reset_async got=%b want=0000", {lr, lg, lb, ps});
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        wait_ps(0, 4, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL reset_restart_ps got=%0d want=1", ok);
        else n_pass++;
        measure(0, 1, 127, 127, 127, -1, 7'd0, 7'd0, 7'd0, cr, cg, cb, se, pe);
        n_checks++;
        if (cr + cg + cb !== 381 || se !== 0 || pe !== 0)
            $display("FAIL reset_after_period got=%0d/%0d/%0d want=381/0/0", cr + cg + cb, se, pe);
        else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        int cr, cg, cb, se, pe;
        start(0, 7'd60, 7'd0, 7'd127, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL basic_entry_ps got=%0d want=1", ok);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            measure(0, 1, 60, 0, 127, -1, 7'd0, 7'd0, 7'd0, cr, cg, cb, se, pe);
            n_checks++;
            if (cr !== 60 || cg !== 0 || cb !== 127)
                $display("FAIL basic_counts got=%0d/%0d/%0d want=60/0/127", cr, cg, cb);
            else n_pass++;
            n_checks++;
            if (se !== 0 || pe !== 0) $display("FAIL basic_shape got=%0d/%0d want=0/0", se, pe);
            else n_pass++;
        end
    endtask

    task automatic test_midchange();
        bit ok;
        int cr, cg, cb, se, pe, want;
        start(0, 7'd60, 7'd0, 7'd127, ok);
        measure(0, 1, 60, 0, 127, 10, 7'd30, 7'd0, 7'd127, cr, cg, cb, se, pe);
        n_checks++;
        if (cr !== 60 || se !== 0 || pe !== 0 || ok !== 1'b1)
            $display("FAIL midchange_cur got=%0d/%0d/%0d want=60/0/0", cr, se, pe);
        else n_pass++;
        want = next_shadow(60, 30);
        measure(0, 1, want, 0, 127, -1, 7'd0, 7'd0, 7'd0, cr, cg, cb, se, pe);
        n_checks++;
        if (cr !== want || se !== 0 || pe !== 0)
            $display("FAIL midchange_next got=%0d/%0d/%0d want=%0d/0/0", cr, se, pe, want);
        else n_pass++;
    endtask

    task automatic test_enable();
        logic lr, lg, lb, ps;
        bit ok;
        int cr, cg, cb, se, pe, bad;
        start(0, 7'd60, 7'd20, 7'd100, ok);
        repeat (40) @(negedge clk);
        read(0, lr, lg, lb, ps);
        n_checks++;
        if ({lr, lg, lb} !== 3'b101) $display("FAIL enable_before got=%b want=101", {lr, lg, lb});
        else n_pass++;
        drive(0, 1'b0, 7'd90, 7'd20, 7'd100);
        @(negedge clk);
        read(0, lr, lg, lb, ps);
        n_checks++;
        if ({lr, lg, lb, ps} !== 4'b0) $display("FAIL enable_off got=%b want=0000", {lr, lg, lb, ps});
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            read(0, lr, lg, lb, ps);
            if ({lr, lg, lb, ps} !== 4'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL enable_idle got=%0d want=0", bad);
        else n_pass++;
        drive(0, 1'b1, 7'd90, 7'd20, 7'd100);
        wait_ps(0, 4, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL enable_reentry_ps got=%0d want=1", ok);
        else n_pass++;
        measure(0, 1, 90, 20, 100, -1, 7'd0, 7'd0, 7'd0, cr, cg, cb, se, pe);
        n_checks++;
        if (cr !== 90 || cg !== 20 || cb !== 100 || se !== 0 || pe !== 0)
            $display("FAIL enable_new_period got=%0d/%0d/%0d/%0d/%0d want=90/20/100/0/0", cr, cg, cb, se, pe);
        else n_pass++;
    endtask

    task automatic test_prescale4();
        bit ok;
        int cr, cg, cb, se, pe;
        start(1, 7'd3, 7'd0, 7'd127, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL pre4_entry_ps got=%0d want=1", ok);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            measure(1, 4, 3, 0, 127, -1, 7'd0, 7'd0, 7'd0, cr, cg, cb, se, pe);
            n_checks++;
            if (cr !== 12 || cg !== 0 || cb !== 508)
                $display("FAIL pre4_counts got=%0d/%0d/%0d want=12/0/508", cr, cg, cb);
            else n_pass++;
            n_checks++;
            if (se !== 0 || pe !== 0) $display("FAIL pre4_shape got=%0d/%0d want=0/0", se, pe);
            else n_pass++;
        end
        drive(1, 1'b0, 7'd0, 7'd0, 7'd0);
    endtask

    task automatic test_fade();
        bit ok;
        int cr, cg, cb, se, pe, sh;
        start(0, 7'd0, 7'd0, 7'd0, ok);
        drive(0, 1'b1, 7'd5, 7'd0, 7'd0);
        sh = 0;
        for (int k = 0; k < 7; k++) begin
            measure(0, 1, sh, 0, 0, -1, 7'd0, 7'd0, 7'd0, cr, cg, cb, se, pe);
            n_checks++;
            if (cr !== sh || se !== 0 || pe !== 0)
                $display("FAIL fade_period%0d got=%0d/%0d/%0d want=%0d/0/0", k, cr, se, pe, sh);
            else n_pass++;
            sh = next_shadow(sh, 5);
        end
    endtask

    task automatic test_random();
        bit ok;
        int cr, cg, cb, se, pe, chg;
        int sr, sg, sb;
        logic [6:0] nr, ng, nb;
        nr = 7'($urandom_range(0, 127));
        ng = 7'($urandom_range(0, 127));
        nb = 7'($urandom_range(0, 127));
        start(0, nr, ng, nb, ok);
        sr = int'(nr); sg = int'(ng); sb = int'(nb);
        for (int k = 0; k < 6; k++) begin
            nr = 7'($urandom_range(0, 127));
            ng = 7'($urandom_range(0, 127));
            nb = 7'($urandom_range(0, 127));
            chg = int'($urandom_range(1, 126));
            measure(0, 1, sr, sg, sb, chg, nr, ng, nb, cr, cg, cb, se, pe);
            n_checks++;
            if (cr !== sr || cg !== sg || cb !== sb || se !== 0 || pe !== 0)
                $display("FAIL random_period%0d got=%0d/%0d/%0d/%0d/%0d want=%0d/%0d/%0d/0/0",
                         k, cr, cg, cb, se, pe, sr, sg, sb);
            else n_pass++;
            sr = next_shadow(sr, int'(nr));
            sg = next_shadow(sg, int'(ng));
            sb = next_shadow(sb, int'(nb));
        end
    endtask

    initial begin
        drive(0, 1'b0, 7'd0, 7'd0, 7'd0);
        drive(1, 1'b0, 7'd0, 7'd0, 7'd0);
        test_reset();
        test_basic();
        test_midchange();
        test_enable();
        test_prescale4();
        test_fade();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks_passed=%0d of %0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end
endmodule
